lcd_ram_reader: RTL
===================

LCD_RAM_READER -- requirements
Module: lcd_ram_reader

Interface
REQ-001 Parameter POWERUP_CYC, default 750000, SHALL set the idle cycles after reset before the first LCD nibble (15 ms at 50 MHz).
REQ-002 Parameter E_PULSE_CYC, default 12, SHALL set the cycles lcd_e is held high per nibble.
REQ-003 Parameter NIBBLE_GAP_CYC, default 50, SHALL set the cycles between the high-nibble and low-nibble strobes of one byte.
REQ-004 Parameter CMD_WAIT_CYC, default 2000, SHALL set the wait after each byte; after clear-display it SHALL be 41×CMD_WAIT_CYC.
REQ-005 Ports:
  clk  in  1  system clock, all logic on rising edge
  reset  in  1  asynchronous, active-high reset
  radd  out  5  character RAM read address
  dout  in  8  character RAM data, combinational in radd
  lcd_d  out  4  LCD data nibble (DB7..DB4)
  lcd_e  out  1  LCD enable strobe
  lcd_rs  out  1  0 = command, 1 = character data
  lcd_rw  out  1  tied 0 (write only)
  busy  out  1  high until the init sequence completes
  refresh_done  out  1  one-cycle pulse after character 31 is written

Function
REQ-006 Nibble transfer SHALL drive lcd_d/lcd_rs 2 cycles before lcd_e rises, hold lcd_e high E_PULSE_CYC cycles, and hold lcd_d/lcd_rs 1 cycle after lcd_e falls.
REQ-007 Byte transfer SHALL send bits [7:4], wait NIBBLE_GAP_CYC, send bits [3:0], then wait the command wait.
REQ-008 States SHALL be PWR_WAIT -> INIT3A -> INIT3B -> INIT3C -> INIT2 -> FUNC_SET -> ENTRY -> DISP_ON -> CLEAR -> SET_ADDR -> WR_CHAR, with WR_CHAR returning to SET_ADDR or WR_CHAR.
REQ-009 INIT3A/B/C SHALL each send single nibble 0x3 and INIT2 single nibble 0x2, each followed by CMD_WAIT_CYC; the first 0x3 uses 5×CMD_WAIT_CYC.
REQ-010 FUNC_SET, ENTRY, DISP_ON and CLEAR SHALL send bytes 0x28, 0x06, 0x0C and 0x01 with lcd_rs=0.
REQ-011 busy SHALL deassert on the cycle SET_ADDR is first entered and stay low until reset.
REQ-012 SET_ADDR SHALL send 0x80 when radd=0 and 0xC0 when radd=16, with lcd_rs=0; it SHALL be entered only at those indices.
REQ-013 WR_CHAR SHALL latch dout exactly one cycle after radd is stable, send it unmodified with lcd_rs=1 (0xFE passes through), then increment radd.
REQ-014 radd SHALL wrap 31 -> 0; on that wrap refresh_done SHALL pulse for one cycle and refresh restarts at SET_ADDR 0x80 without reinit.
REQ-015 RAM writes during refresh SHALL need no coherency; each character is sampled once per pass at its latch cycle.
REQ-016 lcd_rw SHALL be 0 at all times.

Reset
REQ-017 On reset assertion, without waiting for a clock edge, outputs SHALL go to: radd=0, lcd_d=0, lcd_e=0, lcd_rs=0, busy=1, refresh_done=0; state SHALL go to PWR_WAIT and all counters to 0.
REQ-018 Reset mid-nibble SHALL abort the transfer; after release the full power-up and init sequence SHALL repeat.

Structure
REQ-019 Package lcd_pkg SHALL hold the state enum, the init/command byte constants (0x28, 0x06, 0x0C, 0x01, 0x80, 0xC0) and the line-2 index 16.
REQ-020 Nibble/byte timing SHALL be a sub-module lcd_nibble_tx with a start/done handshake: start is accepted only while idle, and done is a one-cycle pulse after the post-byte wait.

Verification (POWERUP_CYC=100, E_PULSE_CYC=4, NIBBLE_GAP_CYC=3, CMD_WAIT_CYC=10)
REQ-021 Release reset -> first lcd_e rise at cycle ≥102, nibbles in order 3,3,3,2,2,8,0,6,0,C,0,1, all with lcd_rs=0; busy low afterwards.
REQ-022 RAM all 0xFE -> nibble stream 8,0, then 16×(F,E with rs=1), then C,0, then 16×(F,E), then refresh_done pulses once.
REQ-023 RAM[5]=0x41 and RAM[20]=0x5A -> the sixth character is nibbles 4,1 and the 21st is 5,A; radd=5 and radd=20 are stable at the respective latch cycles.
REQ-024 Second refresh pass -> after refresh_done, the next byte is 0x80 with no init nibbles, and radd=0.
REQ-025 Assert reset while lcd_e is high during character 10 -> lcd_e=0 and radd=0 before the next clock edge; after release, the REQ-021 sequence repeats.
REQ-026 Whole run -> lcd_rw is never 1, and every lcd_e high pulse is exactly 4 cycles with lcd_d stable from 2 cycles before to 1 cycle after.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command constants for the character-RAM-to-LCD refresher.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT3A,
    INIT3B,
    INIT3C,
    INIT2,
    FUNC_SET,
    ENTRY,
    DISP_ON,
    CLEAR,
    SET_ADDR,
    WR_CHAR
  } lcd_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_HOLD,
    TX_GAP,
    TX_WAIT
  } tx_state_e;

  // Single-nibble init commands carry their nibble in bits [7:4].
  localparam logic [7:0] NIB_INIT3    = 8'h30;
  localparam logic [7:0] NIB_INIT2    = 8'h20;
  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [4:0] LINE2_IDX    = 5'd16;

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one nibble or one byte (high nibble first) on a 4-bit LCD bus, then waits.
// Handshake: start is accepted only while idle=1; done pulses one cycle after the post-transfer wait.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC    = 12,
  parameter int NIBBLE_GAP_CYC = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        single,
  input  logic        rs,
  input  logic [7:0]  data,
  input  logic [31:0] wait_cyc,
  output logic        idle,
  output logic        done,
  output tx_state_e   dbg_state,
  output logic [3:0]  lcd_d,
  output logic        lcd_e,
  output logic        lcd_rs
);

  localparam logic [31:0] PULSE_LEN = 32'(E_PULSE_CYC);
  localparam logic [31:0] GAP_LEN   = 32'(NIBBLE_GAP_CYC);

  tx_state_e   st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        single_q, single_d;
  logic        lo_q, lo_d;
  logic [31:0] wait_q, wait_d;
  logic [3:0]  lcd_d_q, lcd_d_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        done_q, done_d;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    single_d = single_q;
    lo_d     = lo_q;
    wait_d   = wait_q;
    lcd_d_d  = lcd_d_q;
    lcd_e_d  = lcd_e_q;
    lcd_rs_d = lcd_rs_q;
    done_d   = 1'b0;
    case (st_q)
      TX_IDLE: begin
        if (start) begin
          byte_d   = data;
          single_d = single;
          wait_d   = wait_cyc;
          lo_d     = 1'b0;
          lcd_d_d  = data[7:4];
          lcd_rs_d = rs;
          cnt_d    = '0;
          st_d     = TX_SETUP;
        end
      end
      // Data/rs were driven on entry; enable rises after two setup cycles.
      TX_SETUP: begin
        if (cnt_q == 32'd1) begin
          cnt_d   = '0;
          lcd_e_d = 1'b1;
          st_d    = TX_PULSE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      TX_PULSE: begin
        if (cnt_q + 32'd1 >= PULSE_LEN) begin
          cnt_d   = '0;
          lcd_e_d = 1'b0;
          st_d    = TX_HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      TX_HOLD: begin
        cnt_d = '0;
        st_d  = (single_q || lo_q) ? TX_WAIT : TX_GAP;
      end
      TX_GAP: begin
        if (cnt_q + 32'd1 >= GAP_LEN) begin
          cnt_d   = '0;
          lo_d    = 1'b1;
          lcd_d_d = byte_q[3:0];
          st_d    = TX_SETUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      TX_WAIT: begin
        if (cnt_q + 32'd1 >= wait_q) begin
          cnt_d  = '0;
          done_d = 1'b1;
          st_d   = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= TX_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      single_q <= 1'b0;
      lo_q     <= 1'b0;
      wait_q   <= '0;
      lcd_d_q  <= '0;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      single_q <= single_d;
      lo_q     <= lo_d;
      wait_q   <= wait_d;
      lcd_d_q  <= lcd_d_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      done_q   <= done_d;
    end
  end

  assign idle      = (st_q == TX_IDLE);
  assign done      = done_q;
  assign dbg_state = st_q;
  assign lcd_d     = lcd_d_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rs    = lcd_rs_q;

endmodule

// File: rtl/lcd_ram_reader.sv
// Initialises a 4-bit HD44780 LCD, then endlessly copies a 32-entry character RAM to its two lines.
module lcd_ram_reader
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int E_PULSE_CYC    = 12,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int CMD_WAIT_CYC   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] radd,
  input  logic [7:0] dout,
  output logic [3:0] lcd_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       refresh_done
);

  localparam logic [31:0] PWR_LEN  = 32'(POWERUP_CYC);
  localparam logic [31:0] WAIT_CMD = 32'(CMD_WAIT_CYC);
  localparam logic [31:0] WAIT_PWR = 32'(5 * CMD_WAIT_CYC);
  localparam logic [31:0] WAIT_CLR = 32'(41 * CMD_WAIT_CYC);

  lcd_state_e  st_q, st_d;
  logic [31:0] cnt_q, cnt_d;
  logic        issued_q, issued_d;
  logic        start_q, start_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        single_q, single_d;
  logic [31:0] wait_q, wait_d;
  logic [4:0]  radd_q, radd_d;
  logic        busy_q, busy_d;
  logic        refresh_done_q, refresh_done_d;

  logic        tx_idle;
  logic        tx_done;
  tx_state_e   tx_state;

  lcd_nibble_tx #(
    .E_PULSE_CYC   (E_PULSE_CYC),
    .NIBBLE_GAP_CYC(NIBBLE_GAP_CYC)
  ) u_tx (
    .clk      (clk),
    .rst      (reset),
    .start    (start_q),
    .single   (single_q),
    .rs       (rs_q),
    .data     (data_q),
    .wait_cyc (wait_q),
    .idle     (tx_idle),
    .done     (tx_done),
    .dbg_state(tx_state),
    .lcd_d    (lcd_d),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs)
  );

  always_comb begin
    st_d           = st_q;
    cnt_d          = cnt_q;
    issued_d       = issued_q;
    start_d        = 1'b0;
    data_d         = data_q;
    rs_d           = rs_q;
    single_d       = single_q;
    wait_d         = wait_q;
    radd_d         = radd_q;
    busy_d         = busy_q;
    refresh_done_d = 1'b0;
    if (st_q == PWR_WAIT) begin
      if (cnt_q + 32'd1 >= PWR_LEN) begin
        cnt_d = '0;
        st_d  = INIT3A;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (!issued_q) begin
      // Each state issues exactly one transfer; WR_CHAR samples dout here, a cycle after radd settled.
      if (tx_idle) begin
        start_d  = 1'b1;
        issued_d = 1'b1;
        rs_d     = 1'b0;
        single_d = 1'b0;
        wait_d   = WAIT_CMD;
        case (st_q)
          INIT3A: begin
            data_d   = NIB_INIT3;
            single_d = 1'b1;
            wait_d   = WAIT_PWR;
          end
          INIT3B, INIT3C: begin
            data_d   = NIB_INIT3;
            single_d = 1'b1;
          end
          INIT2: begin
            data_d   = NIB_INIT2;
            single_d = 1'b1;
          end
          FUNC_SET: data_d = CMD_FUNC_SET;
          ENTRY:    data_d = CMD_ENTRY;
          DISP_ON:  data_d = CMD_DISP_ON;
          CLEAR: begin
            data_d = CMD_CLEAR;
            wait_d = WAIT_CLR;
          end
          SET_ADDR: data_d = (radd_q == LINE2_IDX) ? CMD_LINE2 : CMD_LINE1;
          WR_CHAR: begin
            data_d = dout;
            rs_d   = 1'b1;
          end
          default: data_d = data_q;
        endcase
      end
    end else if (tx_done) begin
      issued_d = 1'b0;
      case (st_q)
        INIT3A:   st_d = INIT3B;
        INIT3B:   st_d = INIT3C;
        INIT3C:   st_d = INIT2;
        INIT2:    st_d = FUNC_SET;
        FUNC_SET: st_d = ENTRY;
        ENTRY:    st_d = DISP_ON;
        DISP_ON:  st_d = CLEAR;
        CLEAR: begin
          st_d   = SET_ADDR;
          busy_d = 1'b0;
        end
        SET_ADDR: st_d = WR_CHAR;
        WR_CHAR: begin
          radd_d = radd_q + 5'd1;
          if (radd_q == 5'd15 || radd_q == 5'd31) begin
            st_d = SET_ADDR;
          end
          refresh_done_d = (radd_q == 5'd31);
        end
        default: st_d = PWR_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q           <= PWR_WAIT;
      cnt_q          <= '0;
      issued_q       <= 1'b0;
      start_q        <= 1'b0;
      data_q         <= '0;
      rs_q           <= 1'b0;
      single_q       <= 1'b0;
      wait_q         <= '0;
      radd_q         <= '0;
      busy_q         <= 1'b1;
      refresh_done_q <= 1'b0;
    end else begin
      st_q           <= st_d;
      cnt_q          <= cnt_d;
      issued_q       <= issued_d;
      start_q        <= start_d;
      data_q         <= data_d;
      rs_q           <= rs_d;
      single_q       <= single_d;
      wait_q         <= wait_d;
      radd_q         <= radd_d;
      busy_q         <= busy_d;
      refresh_done_q <= refresh_done_d;
    end
  end

  assign radd         = radd_q;
  assign busy         = busy_q;
  assign refresh_done = refresh_done_q;
  assign lcd_rw       = 1'b0;

  logic unused_ok;
  assign unused_ok = ^tx_state;

endmodule
